cntr8_ctrl: RTL and testbench
=============================

Name: cntr8_ctrl

Overview:
- Command-driven sequencer for the 8-bit counter datapath.
- Accepts load/increment/decrement/clear commands over a valid/ready handshake and steps the internal 8-bit count register the requested number of times.
- Drives the 3-bit state code consumed by the counter output-select logic; the code encoding is fixed below.
- Sits between the host/test controller and the cntr8 datapath.

Parameters:
- WIDTH, 8, count and data width.
- LEN_W, 8, width of step-length field.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_op  input  2  00 LOAD, 01 INC, 10 DEC, 11 CLR.
- cmd_len  input  LEN_W  number of INC/DEC steps; ignored for LOAD/CLR.
- cmd_data  input  WIDTH  load value for LOAD.
- abort  input  1  synchronous abort of the running command.
- o_state  output  3  state code to output logic.
- cnt  output  WIDTH  current count register.
- busy  output  1  command in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, reset_n=0):
  - o_state=IDLE, cnt=0, busy=0, done=0, internal step counter=0.
  - cmd_ready=1 after reset release.
- State codes:
  - IDLE=000, LOAD=001, INC=010, INC2=011, DEC=100, DEC2=101.
  - 110 and 111 are unused; if ever reached, go to IDLE next cycle with cnt unchanged.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid & cmd_ready.
  - cmd_ready = (o_state==IDLE) & ~abort.
  - cmd_op, cmd_len and cmd_data are captured at acceptance; later changes to them are ignored.
- LOAD: 1 cycle in LOAD; cnt<=cmd_data at exit; next cycle IDLE with done=1.
- CLR: identical to LOAD with data 0; o_state shows LOAD.
- INC:
  - Occupies N=cmd_len cycles.
  - State alternates INC, INC2, INC, ... starting at INC.
  - cnt increments by 1 on every cycle spent in INC or INC2.
  - After the Nth step, next state is IDLE and done=1 in that IDLE cycle.
- DEC: same as INC using DEC/DEC2, with cnt decrementing by 1 per cycle.
- cmd_len=0 (INC/DEC):
  - Command is accepted and the state stays IDLE.
  - done=1 on the following cycle; cnt unchanged; busy stays 0.
- Status outputs:
  - busy=1 whenever o_state!=IDLE.
  - done is never high for two consecutive cycles.
- Wrap: INC from 8'hFF gives 8'h00; DEC from 8'h00 gives 8'hFF (modulo 2^WIDTH).
- Abort:
  - When abort=1 in a non-IDLE state, the next state is IDLE.
  - The step in that cycle is not applied, cnt keeps its value, and done is not pulsed.
  - abort in IDLE blocks acceptance that cycle.
- Back-to-back: a new command is accepted in the IDLE cycle that carries done, so one idle cycle minimum separates commands.
- Reset asserted mid-command: immediate return to reset values; the command is lost.
- All outputs are registered except cmd_ready, which is decoded from the state register and abort.

Optional Feature:
- Macro CNTR8_CTRL_SAT_EN.
- Defined: INC saturates at 8'hFF and DEC at 8'h00. Remaining steps still consume cycles, cnt holds its value, and done timing is unchanged.
- Not defined: modulo wrap as above.

Decomposition:
- Shared package cntr8_pkg holds:
  - state code localparams (IDLE..DEC2);
  - op code localparams (OP_LOAD, OP_INC, OP_DEC, OP_CLR);
  - WIDTH default.
- Natural sub-module cntr8_ctrl_ns: combinational next-state/next-count logic.
- The top level holds the registers, handshake and step counter.

Test Plan:
- Reset, then LOAD data=8'hA5 → LOAD for 1 cycle, then IDLE with done=1 and cnt=8'hA5.
- LOAD 8'hFD, then INC len=4 → o_state sequence 010,011,010,011,000; cnt 8'hFE,8'hFF,8'h00,8'h01; done on the final IDLE (with CNTR8_CTRL_SAT_EN: cnt ends at 8'hFF).
- LOAD 8'h02, then DEC len=3 → o_state 100,101,100; cnt ends 8'hFF (wrap); busy high for exactly 3 cycles.
- INC len=10 from 0 with abort on the 4th busy cycle → IDLE next cycle, cnt=3, no done pulse, cmd_ready high afterward.
- INC len=0 → state stays IDLE, done pulses once, cnt unchanged; then CLR → cnt=0.
- Assert reset_n low mid-DEC → o_state=000, cnt=0, busy=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cntr8_pkg.sv
// Shared state/op encodings and default widths for the cntr8 command sequencer.
package cntr8_pkg;

  localparam int CNTR8_WIDTH = 8;
  localparam int CNTR8_LEN_W = 8;

  localparam logic [2:0] IDLE = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] INC  = 3'b010;
  localparam logic [2:0] INC2 = 3'b011;
  localparam logic [2:0] DEC  = 3'b100;
  localparam logic [2:0] DEC2 = 3'b101;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  // Codes 110/111 are deliberately left out; they recover through the default branch.
  typedef enum logic [2:0] {
    ST_IDLE = IDLE,
    ST_LOAD = LOAD,
    ST_INC  = INC,
    ST_INC2 = INC2,
    ST_DEC  = DEC,
    ST_DEC2 = DEC2
  } state_t;

endpackage

// File: rtl/cntr8_ctrl_ns.sv
// Combinational next-state / next-count logic for cntr8_ctrl.
// Define CNTR8_CTRL_SAT_EN to saturate INC at all-ones and DEC at zero instead of wrapping.
module cntr8_ctrl_ns
  import cntr8_pkg::*;
#(
  parameter int WIDTH = CNTR8_WIDTH,
  parameter int LEN_W = CNTR8_LEN_W
) (
  input  state_t             state,
  input  logic [WIDTH-1:0]   cnt,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [LEN_W-1:0]   step_cnt,
  input  logic               abort,
  input  logic               accept,
  input  logic               done,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  output state_t             state_next,
  output logic [WIDTH-1:0]   cnt_next,
  output logic [LEN_W-1:0]   step_next,
  output logic               done_next
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAXV = '1;

  logic [WIDTH-1:0] cnt_up;
  logic [WIDTH-1:0] cnt_dn;
  logic             last_step;

`ifdef CNTR8_CTRL_SAT_EN
  assign cnt_up = (cnt == MAXV) ? cnt : cnt + ONE;
  assign cnt_dn = (cnt == '0)   ? cnt : cnt - ONE;
`else
  assign cnt_up = cnt + ONE;
  assign cnt_dn = cnt - ONE;
`endif

  assign last_step = (step_cnt == LEN_W'(1));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    step_next  = step_cnt;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD, OP_CLR: state_next = ST_LOAD;
            default: begin
              // A zero-length step completes at once; if it lands on an existing
              // done pulse it merges with it so done never stays high two cycles.
              if (cmd_len == '0) begin
                done_next = ~done;
              end else begin
                state_next = (cmd_op == OP_INC) ? ST_INC : ST_DEC;
                step_next  = cmd_len;
              end
            end
          endcase
        end
      end
      ST_LOAD: begin
        state_next = ST_IDLE;
        if (!abort) begin
          cnt_next  = load_val;
          done_next = 1'b1;
        end
      end
      ST_INC, ST_INC2, ST_DEC, ST_DEC2: begin
        if (abort) begin
          state_next = ST_IDLE;
          step_next  = '0;
        end else begin
          cnt_next  = (state == ST_INC || state == ST_INC2) ? cnt_up : cnt_dn;
          step_next = step_cnt - LEN_W'(1);
          if (last_step) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            case (state)
              ST_INC:  state_next = ST_INC2;
              ST_INC2: state_next = ST_INC;
              ST_DEC:  state_next = ST_DEC2;
              default: state_next = ST_DEC;
            endcase
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        step_next  = '0;
      end
    endcase
  end

endmodule

// File: rtl/cntr8_ctrl.sv
// Command sequencer for the cntr8 datapath: registers, handshake and step counter.
// Saturating INC/DEC is selected with the CNTR8_CTRL_SAT_EN macro (see cntr8_ctrl_ns).
module cntr8_ctrl
  import cntr8_pkg::*;
#(
  parameter int WIDTH = CNTR8_WIDTH,
  parameter int LEN_W = CNTR8_LEN_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic [2:0]       o_state,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] load_val;
  logic [LEN_W-1:0] step_cnt;
  logic [LEN_W-1:0] step_next;
  logic             done_next;
  logic             accept;

  assign cmd_ready = (state == ST_IDLE) & ~abort;
  assign accept    = cmd_valid & cmd_ready;
  assign o_state   = state;

  cntr8_ctrl_ns #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_ns (
    .state      (state),
    .cnt        (cnt),
    .load_val   (load_val),
    .step_cnt   (step_cnt),
    .abort      (abort),
    .accept     (accept),
    .done       (done),
    .cmd_op     (cmd_op),
    .cmd_len    (cmd_len),
    .state_next (state_next),
    .cnt_next   (cnt_next),
    .step_next  (step_next),
    .done_next  (done_next)
  );

  // CLR reuses the LOAD path, so the captured load value is forced to zero here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      step_cnt <= '0;
      load_val <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      step_cnt <= step_next;
      busy     <= (state_next != ST_IDLE);
      done     <= done_next;
      if (accept) begin
        load_val <= (cmd_op == OP_CLR) ? '0 : cmd_data;
      end
    end
  end

endmodule

// File: tb/tb_cntr8_ctrl.sv
// Self-checking bench for cntr8_ctrl: directed scenarios plus randomized commands
// compared against a per-command expected trace built from the behavioural rules.
module tb_cntr8_ctrl;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_len;
  logic [7:0] cmd_data;
  logic       abort;
  logic [2:0] o_state;
  logic [7:0] cnt;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  logic [7:0] model_cnt = 8'h00;
  logic       last_done = 1'b0;

  typedef struct {
    logic [2:0] st;
    logic [7:0] c;
    logic       b;
    logic       d;
  } exp_t;

  cntr8_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .o_state   (o_state),
    .cnt       (cnt),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st, input logic [7:0] c, input logic b, input logic d);
    exp_t e;
    e.st = st; e.c = c; e.b = b; e.d = d;
    return e;
  endfunction

  // One INC (op 1) or DEC (op 2) step of the count.
  function automatic logic [7:0] step_val(input logic [1:0] op, input logic [7:0] v);
`ifdef CNTR8_CTRL_SAT_EN
    if (op == 2'd1) return (v == 8'hFF) ? v : v + 8'd1;
    else            return (v == 8'h00) ? v : v - 8'd1;
`else
    return (op == 2'd1) ? v + 8'd1 : v - 8'd1;
`endif
  endfunction

  // Issue one command (starting just after a negedge in an IDLE cycle) and follow it
  // cycle by cycle to its closing IDLE cycle; abort_idx selects a busy cycle to abort.
  task automatic applyStimulus(input logic [1:0] op, input int len, input logic [7:0] data, input int abort_idx);
    exp_t q[$];
    logic [7:0] v;
    logic [2:0] base;
    bit ab;
    cmd_op = op; cmd_len = len[7:0]; cmd_data = data; cmd_valid = 1'b1;
    #1 checkOutput("ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_len = 8'($urandom); cmd_data = 8'($urandom);
    v = model_cnt;
    ab = 1'b0;
    if (op == 2'd0 || op == 2'd3) begin
      q.push_back(mk(3'b001, v, 1'b1, 1'b0));
      if (abort_idx == 0) begin
        q.push_back(mk(3'b000, v, 1'b0, 1'b0));
      end else begin
        v = (op == 2'd3) ? 8'h00 : data;
        q.push_back(mk(3'b000, v, 1'b0, 1'b1));
      end
    end else if (len == 0) begin
      q.push_back(mk(3'b000, v, 1'b0, ~last_done));
    end else begin
      base = (op == 2'd1) ? 3'b010 : 3'b100;
      for (int k = 0; k < len; k++) begin
        q.push_back(mk(base | 3'(k % 2), v, 1'b1, 1'b0));
        if (k == abort_idx) begin
          ab = 1'b1;
          break;
        end
        v = step_val(op, v);
      end
      q.push_back(mk(3'b000, v, 1'b0, ~ab));
    end
    for (int i = 0; i < q.size(); i++) begin
      if (i == abort_idx) abort = 1'b1;
      @(negedge clk);
      checkOutput("o_state", o_state, q[i].st);
      checkOutput("cnt", cnt, q[i].c);
      checkOutput("busy", busy, q[i].b);
      checkOutput("done", done, q[i].d);
      if (i != q.size() - 1) begin
        @(posedge clk); #1;
        abort = 1'b0;
      end
    end
    checkOutput("ready_after", cmd_ready, 1);
    model_cnt = v;
    last_done = q[q.size()-1].d;
  endtask

  initial begin
    int op_r, len_r, ab_r, nbusy;
    logic [7:0] data_r;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_len = 8'd0; cmd_data = 8'd0; abort = 1'b0;
    #1;
    checkOutput("rst_state", o_state, 0);
    checkOutput("rst_cnt", cnt, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1 checkOutput("rst_ready", cmd_ready, 1);

    $display("[TB] directed: load, inc wrap, dec wrap, abort, zero length, clr");
    applyStimulus(2'd0, 0, 8'hA5, -1);
    applyStimulus(2'd0, 0, 8'hFD, -1);
    applyStimulus(2'd1, 4, 8'h00, -1);
    applyStimulus(2'd0, 0, 8'h02, -1);
    applyStimulus(2'd2, 3, 8'h00, -1);
    applyStimulus(2'd3, 0, 8'h77, -1);
    applyStimulus(2'd1, 10, 8'h00, 3);
    applyStimulus(2'd1, 0, 8'h00, -1);
    applyStimulus(2'd0, 0, 8'h5A, -1);
    applyStimulus(2'd3, 0, 8'h99, -1);

    $display("[TB] abort while idle blocks acceptance");
    cmd_op = 2'd0; cmd_data = 8'h33; cmd_valid = 1'b1; abort = 1'b1;
    #1 checkOutput("ready_abort", cmd_ready, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0; abort = 1'b0;
    @(negedge clk);
    checkOutput("blk_state", o_state, 0);
    checkOutput("blk_busy", busy, 0);
    checkOutput("blk_cnt", cnt, model_cnt);
    checkOutput("blk_done", done, 0);
    last_done = 1'b0;

    $display("[TB] randomized commands");
    for (int n = 0; n < 60; n++) begin
      op_r   = int'($urandom_range(0, 3));
      len_r  = int'($urandom_range(0, 12));
      data_r = 8'($urandom_range(0, 255));
      nbusy  = (op_r == 0 || op_r == 3) ? 1 : len_r;
      ab_r   = -1;
      if (nbusy > 0 && $urandom_range(0, 3) == 0) ab_r = int'($urandom_range(0, nbusy - 1));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); @(negedge clk);
        checkOutput("gap_state", o_state, 0);
        checkOutput("gap_done", done, 0);
        last_done = 1'b0;
      end
      applyStimulus(2'(op_r), len_r, data_r, ab_r);
    end

    $display("[TB] reset asserted mid-command");
    applyStimulus(2'd0, 0, 8'h40, -1);
    cmd_op = 2'd2; cmd_len = 8'd6; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #3;
    checkOutput("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_state", o_state, 0);
    checkOutput("mid_rst_cnt", cnt, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 checkOutput("post_rst_ready", cmd_ready, 1);
    @(negedge clk);
    checkOutput("post_rst_state", o_state, 0);
    checkOutput("post_rst_cnt", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
